// File: rtl/axi_ic_pkg.sv
// Shared definitions for the interconnect read/write channel controllers:
// FSM encoding, BRESP codes, master/slave indices and the arbitration helper.
package axi_ic_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAw   = 2'd1,
      StW    = 2'd2,
      StB    = 2'd3
   } ic_state_e;

   localparam logic [1:0] BrespOkay   = 2'b00;
   localparam logic [1:0] BrespDecerr = 2'b11;

   localparam logic MasterM0 = 1'b0;
   localparam logic MasterM1 = 1'b1;
   localparam logic SlaveS0  = 1'b0;
   localparam logic SlaveS1  = 1'b1;

   // Two-way round robin: on contention the master not granted last time wins.
   function automatic logic rr_grant(input logic m0_valid, input logic m1_valid,
                                     input logic last_grant);
      if (m0_valid && m1_valid) begin
         return ~last_grant;
      end
      return m1_valid ? MasterM1 : MasterM0;
   endfunction

endpackage

// File: rtl/write_channel_controller_if.sv
// Handshake and routing signals between the write channel controller and the fabric.
// master: the controller's view; slave: the surrounding masters/slaves/muxes.
interface write_channel_controller_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 8
) ();

   logic [ADDR_W-1:0] slave0_addr1;
   logic [ADDR_W-1:0] slave0_addr2;
   logic [ADDR_W-1:0] slave1_addr1;
   logic [ADDR_W-1:0] slave1_addr2;

   logic [ADDR_W-1:0] M0_AWADDR;
   logic [ADDR_W-1:0] M1_AWADDR;
   logic              M0_AWVALID;
   logic              M1_AWVALID;
   logic              S0_AWREADY;
   logic              S1_AWREADY;
   logic              M0_WVALID;
   logic              M1_WVALID;
   logic              M0_WLAST;
   logic              M1_WLAST;
   logic              S0_WREADY;
   logic              S1_WREADY;
   logic              S0_BVALID;
   logic              S1_BVALID;
   logic              M0_BREADY;
   logic              M1_BREADY;

   logic              sel_master;
   logic              sel_slave;
   logic              aw_en;
   logic              w_en;
   logic              b_en;
   logic              err_awready;
   logic              err_wready;
   logic              err_bvalid;
   logic [1:0]        err_bresp;
   logic [CNT_W-1:0]  w_beat_count;

   modport master (
      input  slave0_addr1, slave0_addr2, slave1_addr1, slave1_addr2,
      input  M0_AWADDR, M1_AWADDR, M0_AWVALID, M1_AWVALID, S0_AWREADY, S1_AWREADY,
      input  M0_WVALID, M1_WVALID, M0_WLAST, M1_WLAST, S0_WREADY, S1_WREADY,
      input  S0_BVALID, S1_BVALID, M0_BREADY, M1_BREADY,
      output sel_master, sel_slave, aw_en, w_en, b_en,
      output err_awready, err_wready, err_bvalid, err_bresp, w_beat_count
   );

   modport slave (
      output slave0_addr1, slave0_addr2, slave1_addr1, slave1_addr2,
      output M0_AWADDR, M1_AWADDR, M0_AWVALID, M1_AWVALID, S0_AWREADY, S1_AWREADY,
      output M0_WVALID, M1_WVALID, M0_WLAST, M1_WLAST, S0_WREADY, S1_WREADY,
      output S0_BVALID, S1_BVALID, M0_BREADY, M1_BREADY,
      input  sel_master, sel_slave, aw_en, w_en, b_en,
      input  err_awready, err_wready, err_bvalid, err_bresp, w_beat_count
   );

endinterface

// File: rtl/wc_addr_decoder.sv
// Combinational address decode against two inclusive ranges; slave 0 wins on overlap.
module wc_addr_decoder
   import axi_ic_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] s0_lo,
   input  logic [ADDR_W-1:0] s0_hi,
   input  logic [ADDR_W-1:0] s1_lo,
   input  logic [ADDR_W-1:0] s1_hi,
   output logic              slave_idx,
   output logic              dec_err
);

   logic in_s0;
   logic in_s1;

   assign in_s0 = (addr >= s0_lo) && (addr <= s0_hi);
   assign in_s1 = (addr >= s1_lo) && (addr <= s1_hi);

   always_comb begin
      slave_idx = SlaveS0;
      dec_err   = 1'b0;
      if (in_s0) begin
         slave_idx = SlaveS0;
      end else if (in_s1) begin
         slave_idx = SlaveS1;
      end else begin
         dec_err = 1'b1;
      end
   end

endmodule

// File: rtl/write_channel_controller.sv
// Write-side interconnect controller: arbitrates two masters, routes AW/W/B to one of
// two slaves, and answers unmapped addresses with an internal DECERR responder.
module write_channel_controller
   import axi_ic_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 8
) (
   input logic                        clkk,
   input logic                        resett,
   write_channel_controller_if.master bus
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   ic_state_e        state_q;
   logic             sel_master_q;
   logic             sel_slave_q;
   logic             aw_en_q;
   logic             w_en_q;
   logic             b_en_q;
   logic             err_awready_q;
   logic             err_wready_q;
   logic             err_bvalid_q;
   logic [1:0]       err_bresp_q;
   logic [CNT_W-1:0] w_beat_count_q;
   logic             dec_err_q;
   logic             last_grant_q;

   logic              grant;
   logic [ADDR_W-1:0] grant_addr;
   logic              dec_slave;
   logic              dec_err;

   assign grant      = rr_grant(bus.M0_AWVALID, bus.M1_AWVALID, last_grant_q);
   assign grant_addr = grant ? bus.M1_AWADDR : bus.M0_AWADDR;

   wc_addr_decoder #(
      .ADDR_W (ADDR_W)
   ) u_dec (
      .addr      (grant_addr),
      .s0_lo     (bus.slave0_addr1),
      .s0_hi     (bus.slave0_addr2),
      .s1_lo     (bus.slave1_addr1),
      .s1_hi     (bus.slave1_addr2),
      .slave_idx (dec_slave),
      .dec_err   (dec_err)
   );

   // Handshake signals of the currently granted master / selected slave.
   logic g_awvalid, g_wvalid, g_wlast, g_bready;
   logic s_awready, s_wready, s_bvalid;
   logic w_beat, b_done;

   assign g_awvalid = sel_master_q ? bus.M1_AWVALID : bus.M0_AWVALID;
   assign g_wvalid  = sel_master_q ? bus.M1_WVALID  : bus.M0_WVALID;
   assign g_wlast   = sel_master_q ? bus.M1_WLAST   : bus.M0_WLAST;
   assign g_bready  = sel_master_q ? bus.M1_BREADY  : bus.M0_BREADY;
   assign s_awready = sel_slave_q  ? bus.S1_AWREADY : bus.S0_AWREADY;
   assign s_wready  = sel_slave_q  ? bus.S1_WREADY  : bus.S0_WREADY;
   assign s_bvalid  = sel_slave_q  ? bus.S1_BVALID  : bus.S0_BVALID;

   assign w_beat = g_wvalid && ((w_en_q && s_wready) || err_wready_q);
   assign b_done = g_bready && (err_bvalid_q || (b_en_q && s_bvalid));

   always_ff @(posedge clkk or negedge resett) begin
      if (!resett) begin
         state_q        <= StIdle;
         sel_master_q   <= MasterM0;
         sel_slave_q    <= SlaveS0;
         aw_en_q        <= 1'b0;
         w_en_q         <= 1'b0;
         b_en_q         <= 1'b0;
         err_awready_q  <= 1'b0;
         err_wready_q   <= 1'b0;
         err_bvalid_q   <= 1'b0;
         err_bresp_q    <= BrespOkay;
         w_beat_count_q <= '0;
         dec_err_q      <= 1'b0;
         last_grant_q   <= MasterM1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.M0_AWVALID || bus.M1_AWVALID) begin
                  sel_master_q  <= grant;
                  sel_slave_q   <= dec_err ? SlaveS0 : dec_slave;
                  dec_err_q     <= dec_err;
                  aw_en_q       <= !dec_err;
                  err_awready_q <= dec_err;
                  state_q       <= StAw;
               end
            end
            StAw: begin
               // The error responder accepts the address unconditionally in one cycle.
               if (dec_err_q) begin
                  err_awready_q  <= 1'b0;
                  err_wready_q   <= 1'b1;
                  w_beat_count_q <= '0;
                  state_q        <= StW;
               end else if (g_awvalid && s_awready) begin
                  aw_en_q        <= 1'b0;
                  w_en_q         <= 1'b1;
                  w_beat_count_q <= '0;
                  state_q        <= StW;
               end
            end
            StW: begin
               if (w_beat) begin
                  if (w_beat_count_q != CntMax) begin
                     w_beat_count_q <= w_beat_count_q + CNT_W'(1);
                  end
                  if (g_wlast) begin
                     w_en_q       <= 1'b0;
                     err_wready_q <= 1'b0;
                     b_en_q       <= !dec_err_q;
                     err_bvalid_q <= dec_err_q;
                     err_bresp_q  <= dec_err_q ? BrespDecerr : BrespOkay;
                     state_q      <= StB;
                  end
               end
            end
            StB: begin
               if (b_done) begin
                  b_en_q       <= 1'b0;
                  err_bvalid_q <= 1'b0;
                  err_bresp_q  <= BrespOkay;
                  last_grant_q <= sel_master_q;
                  dec_err_q    <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.sel_master   = sel_master_q;
   assign bus.sel_slave    = sel_slave_q;
   assign bus.aw_en        = aw_en_q;
   assign bus.w_en         = w_en_q;
   assign bus.b_en         = b_en_q;
   assign bus.err_awready  = err_awready_q;
   assign bus.err_wready   = err_wready_q;
   assign bus.err_bvalid   = err_bvalid_q;
   assign bus.err_bresp    = err_bresp_q;
   assign bus.w_beat_count = w_beat_count_q;

endmodule
